// File: rtl/int_rs_collapse_mi_pkg.sv
// Shared types, sizes and CDB helpers for the collapsing multi-issue integer
// reservation station.
package int_rs_collapse_mi_pkg;

    localparam int unsigned DEPTH       = 8;
    localparam int unsigned DISP_WIDTH  = 2;
    localparam int unsigned ISSUE_WIDTH = 2;
    localparam int unsigned CDB_WIDTH   = 2;
    localparam int unsigned PRF_IDX     = 6;
    localparam int unsigned PAYLOAD_W   = 64;
    localparam int unsigned IDX_W       = $clog2(DEPTH);
    localparam int unsigned CNT_W       = IDX_W + 1;

    typedef struct packed {
        logic [PRF_IDX-1:0]   rs1_phy;
        logic                 rs1_use;
        logic                 rs1_rdy;
        logic [PRF_IDX-1:0]   rs2_phy;
        logic                 rs2_use;
        logic                 rs2_rdy;
        logic [PAYLOAD_W-1:0] payload;
    } int_rs_entry_t;

    typedef struct packed {
        logic [PRF_IDX-1:0]   rs1_phy;
        logic [PRF_IDX-1:0]   rs2_phy;
        logic [PAYLOAD_W-1:0] payload;
    } int_rs_iss_t;

    function automatic logic cdb_hit(input logic [CDB_WIDTH-1:0]         vld,
                                     input logic [CDB_WIDTH*PRF_IDX-1:0] tags,
                                     input logic [PRF_IDX-1:0]           tag);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            hit |= vld[k] & (tags[k*PRF_IDX +: PRF_IDX] == tag);
        end
        return hit;
    endfunction

    function automatic int_rs_entry_t wake(input int_rs_entry_t              e,
                                           input logic [CDB_WIDTH-1:0]         vld,
                                           input logic [CDB_WIDTH*PRF_IDX-1:0] tags);
        int_rs_entry_t w;
        w         = e;
        w.rs1_rdy = e.rs1_rdy | cdb_hit(vld, tags, e.rs1_phy);
        w.rs2_rdy = e.rs2_rdy | cdb_hit(vld, tags, e.rs2_phy);
        return w;
    endfunction

    function automatic logic entry_ready(input int_rs_entry_t e);
        return (!e.rs1_use | e.rs1_rdy) & (!e.rs2_use | e.rs2_rdy);
    endfunction

endpackage

// File: rtl/int_rs_collapse_mi_if.sv
// Dispatch, CDB wakeup and issue bus of the integer reservation station.
interface int_rs_collapse_mi_if;
    import int_rs_collapse_mi_pkg::*;

    logic [DISP_WIDTH-1:0]            disp_valid;
    logic                             disp_ready;
    logic [DISP_WIDTH*PRF_IDX-1:0]    disp_rs1_phy;
    logic [DISP_WIDTH-1:0]            disp_rs1_use;
    logic [DISP_WIDTH-1:0]            disp_rs1_rdy;
    logic [DISP_WIDTH*PRF_IDX-1:0]    disp_rs2_phy;
    logic [DISP_WIDTH-1:0]            disp_rs2_use;
    logic [DISP_WIDTH-1:0]            disp_rs2_rdy;
    logic [DISP_WIDTH*PAYLOAD_W-1:0]  disp_payload;
    logic [CDB_WIDTH-1:0]             cdb_valid;
    logic [CDB_WIDTH*PRF_IDX-1:0]     cdb_rd_phy;
    logic [ISSUE_WIDTH-1:0]           iss_valid;
    logic [ISSUE_WIDTH-1:0]           iss_ready;
    logic [ISSUE_WIDTH*PRF_IDX-1:0]   iss_rs1_phy;
    logic [ISSUE_WIDTH*PRF_IDX-1:0]   iss_rs2_phy;
    logic [ISSUE_WIDTH*PAYLOAD_W-1:0] iss_payload;
    logic [CNT_W-1:0]                 occupancy;

    modport master (
        output disp_valid, disp_rs1_phy, disp_rs1_use, disp_rs1_rdy,
               disp_rs2_phy, disp_rs2_use, disp_rs2_rdy, disp_payload,
               cdb_valid, cdb_rd_phy, iss_ready,
        input  disp_ready, iss_valid, iss_rs1_phy, iss_rs2_phy, iss_payload, occupancy
    );

    modport slave (
        input  disp_valid, disp_rs1_phy, disp_rs1_use, disp_rs1_rdy,
               disp_rs2_phy, disp_rs2_use, disp_rs2_rdy, disp_payload,
               cdb_valid, cdb_rd_phy, iss_ready,
        output disp_ready, iss_valid, iss_rs1_phy, iss_rs2_phy, iss_payload, occupancy
    );

endinterface

// File: rtl/int_rs_collapse_mi_select.sv
// Oldest-first multi-grant select: lane k is granted the k-th set bit of ready_i
// counting up from entry 0.
module int_rs_collapse_mi_select #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Lanes = 2
) (
    input  logic [Depth-1:0]            ready_i,
    output logic [Lanes-1:0][Depth-1:0] grant_o
);

    always_comb begin
        int cnt;
        cnt     = 0;
        grant_o = '0;
        for (int i = 0; i < Depth; i++) begin
            for (int k = 0; k < Lanes; k++) begin
                grant_o[k][i] = ready_i[i] && (cnt == k);
            end
            if (ready_i[i]) begin
                cnt = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/int_rs_collapse_mi.sv
// Age-ordered collapsing integer RS with multi-slot dispatch and multi-lane issue.
// Define INT_RS_CDB_BYPASS_EN to let same-cycle CDB matches make entries selectable.
module int_rs_collapse_mi
    import int_rs_collapse_mi_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    input logic                 flush,
    int_rs_collapse_mi_if.slave bus
);

    logic [CNT_W-1:0]                   count_q, count_d;
    int_rs_entry_t                      ent_q [DEPTH];
    int_rs_entry_t                      ent_d [DEPTH];
    int_rs_entry_t                      woken [DEPTH];
    int_rs_entry_t                      disp_ent [DISP_WIDTH];
    int_rs_iss_t                        lane [ISSUE_WIDTH];
    logic [DEPTH-1:0]                   valid, ready, removed;
    logic [ISSUE_WIDTH-1:0][DEPTH-1:0]  grant;
    logic [ISSUE_WIDTH-1:0]             lane_vld;
    logic [DISP_WIDTH-1:0]              accept;
    logic                               disp_ok;

    // Space check uses registered occupancy only, so same-cycle issue never helps dispatch.
    assign disp_ok        = (count_q <= CNT_W'(DEPTH - DISP_WIDTH));
    assign bus.disp_ready = disp_ok;
    assign bus.occupancy  = count_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = (CNT_W'(i) < count_q);
            woken[i] = wake(ent_q[i], bus.cdb_valid, bus.cdb_rd_phy);
`ifdef INT_RS_CDB_BYPASS_EN
            ready[i] = valid[i] & entry_ready(woken[i]);
`else
            ready[i] = valid[i] & entry_ready(ent_q[i]);
`endif
        end
    end

    int_rs_collapse_mi_select #(
        .Depth (DEPTH),
        .Lanes (ISSUE_WIDTH)
    ) u_select (
        .ready_i (ready),
        .grant_o (grant)
    );

    always_comb begin
        removed = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            lane[k]     = '0;
            lane_vld[k] = (|grant[k]) & ~flush;
            for (int i = 0; i < DEPTH; i++) begin
                if (grant[k][i]) begin
                    lane[k].rs1_phy = ent_q[i].rs1_phy;
                    lane[k].rs2_phy = ent_q[i].rs2_phy;
                    lane[k].payload = ent_q[i].payload;
                end
                removed[i] = removed[i] | (grant[k][i] & lane_vld[k] & bus.iss_ready[k]);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            bus.iss_valid[k]                         = lane_vld[k];
            bus.iss_rs1_phy[k*PRF_IDX +: PRF_IDX]    = lane[k].rs1_phy;
            bus.iss_rs2_phy[k*PRF_IDX +: PRF_IDX]    = lane[k].rs2_phy;
            bus.iss_payload[k*PAYLOAD_W +: PAYLOAD_W] = lane[k].payload;
        end
    end

    // Incoming slots are woken here too so a tag broadcast on the dispatch cycle is kept.
    always_comb begin
        for (int s = 0; s < DISP_WIDTH; s++) begin
            int_rs_entry_t e;
            e.rs1_phy   = bus.disp_rs1_phy[s*PRF_IDX +: PRF_IDX];
            e.rs1_use   = bus.disp_rs1_use[s];
            e.rs1_rdy   = bus.disp_rs1_rdy[s];
            e.rs2_phy   = bus.disp_rs2_phy[s*PRF_IDX +: PRF_IDX];
            e.rs2_use   = bus.disp_rs2_use[s];
            e.rs2_rdy   = bus.disp_rs2_rdy[s];
            e.payload   = bus.disp_payload[s*PAYLOAD_W +: PAYLOAD_W];
            disp_ent[s] = wake(e, bus.cdb_valid, bus.cdb_rd_phy);
            accept[s]   = bus.disp_valid[s] & disp_ok & ~flush;
        end
    end

    // Survivors compact toward entry 0, then accepted slots are appended in slot order.
    always_comb begin
        int wp;
        wp = 0;
        for (int j = 0; j < DEPTH; j++) begin
            ent_d[j] = ent_q[j];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && !removed[i]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == wp) begin
                        ent_d[j] = woken[i];
                    end
                end
                wp = wp + 1;
            end
        end
        for (int s = 0; s < DISP_WIDTH; s++) begin
            if (accept[s]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == wp) begin
                        ent_d[j] = disp_ent[s];
                    end
                end
                wp = wp + 1;
            end
        end
        count_d = flush ? '0 : CNT_W'(wp);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                ent_q[j] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int j = 0; j < DEPTH; j++) begin
                ent_q[j] <= ent_d[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (count_d <= CNT_W'(DEPTH));
        end
    end

endmodule

// File: tb/tb_int_rs_collapse_mi.sv
// Self-checking bench for int_rs_collapse_mi: issue scoreboard plus per-scenario checks.
module tb_int_rs_collapse_mi;
    import int_rs_collapse_mi_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [PAYLOAD_W-1:0] exp_q[$];
    logic [PAYLOAD_W-1:0] mon_got, mon_want;

    int_rs_collapse_mi_if bus ();

    int_rs_collapse_mi u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: each accepted issue handshake pops the next expected payload.
    always begin
        @(negedge clk);
        #3;
        if (rst) begin
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                if (bus.iss_valid[k] && bus.iss_ready[k]) begin
                    mon_got = bus.iss_payload[k*PAYLOAD_W +: PAYLOAD_W];
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected lane%0d got %h want none", k, mon_got);
                    end else begin
                        mon_want = exp_q.pop_front();
                        if (mon_got !== mon_want) begin
                            n_err++;
                            $display("FAIL sb_payload lane%0d got %h want %h", k, mon_got, mon_want);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.disp_valid   = '0;
        bus.disp_rs1_phy = '0;
        bus.disp_rs1_use = '0;
        bus.disp_rs1_rdy = '0;
        bus.disp_rs2_phy = '0;
        bus.disp_rs2_use = '0;
        bus.disp_rs2_rdy = '0;
        bus.disp_payload = '0;
        bus.cdb_valid    = '0;
        bus.cdb_rd_phy   = '0;
        bus.iss_ready    = '0;
        flush            = 1'b0;
    endtask

    task automatic set_slot(input int s, input logic [PRF_IDX-1:0] t1, input logic u1,
                            input logic r1, input logic [PRF_IDX-1:0] t2, input logic u2,
                            input logic r2, input logic [PAYLOAD_W-1:0] pl);
        bus.disp_valid[s]                          = 1'b1;
        bus.disp_rs1_phy[s*PRF_IDX +: PRF_IDX]     = t1;
        bus.disp_rs1_use[s]                        = u1;
        bus.disp_rs1_rdy[s]                        = r1;
        bus.disp_rs2_phy[s*PRF_IDX +: PRF_IDX]     = t2;
        bus.disp_rs2_use[s]                        = u2;
        bus.disp_rs2_rdy[s]                        = r2;
        bus.disp_payload[s*PAYLOAD_W +: PAYLOAD_W] = pl;
    endtask

    task automatic set_cdb(input int p, input logic [PRF_IDX-1:0] tag);
        bus.cdb_valid[p]                     = 1'b1;
        bus.cdb_rd_phy[p*PRF_IDX +: PRF_IDX] = tag;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        set_slot(0, 6'd1, 1'b0, 1'b0, 6'd2, 1'b0, 1'b0, 64'hBAD0);
        set_slot(1, 6'd3, 1'b0, 1'b0, 6'd4, 1'b0, 1'b0, 64'hBAD1);
        bus.iss_ready = '1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.occupancy !== 4'd0) begin
            n_err++; $display("FAIL reset_occ got %0d want 0", bus.occupancy);
        end
        n_cmp++;
        if (bus.iss_valid !== 2'b00) begin
            n_err++; $display("FAIL reset_iss_valid got %b want 00", bus.iss_valid);
        end
        n_cmp++;
        if (bus.disp_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_disp_ready got %b want 1", bus.disp_ready);
        end
        rst = 1'b1;
        clear_inputs();
    endtask

    task automatic test_dual_issue();
        set_slot(0, 6'd1, 1'b1, 1'b1, 6'd2, 1'b0, 1'b0, 64'hA0);
        set_slot(1, 6'd3, 1'b0, 1'b0, 6'd4, 1'b1, 1'b1, 64'hB0);
        bus.iss_ready = 2'b11;
        exp_q.push_back(64'hA0);
        exp_q.push_back(64'hB0);
        @(negedge clk);
        n_cmp++;
        if (bus.iss_valid !== 2'b11) begin
            n_err++; $display("FAIL dual_iss_valid got %b want 11", bus.iss_valid);
        end
        n_cmp++;
        if (bus.iss_payload[63:0] !== 64'hA0 || bus.iss_payload[127:64] !== 64'hB0) begin
            n_err++; $display("FAIL dual_lanes got %h want A0/B0", bus.iss_payload);
        end
        n_cmp++;
        if (bus.iss_rs1_phy[5:0] !== 6'd1 || bus.iss_rs2_phy[11:6] !== 6'd4) begin
            n_err++; $display("FAIL dual_tags got %h/%h want 1/4", bus.iss_rs1_phy[5:0],
                              bus.iss_rs2_phy[11:6]);
        end
        clear_inputs();
        bus.iss_ready = 2'b11;
        @(negedge clk);
        n_cmp++;
        if (bus.occupancy !== 4'd0) begin
            n_err++; $display("FAIL dual_occ got %0d want 0", bus.occupancy);
        end
        clear_inputs();
    endtask

    task automatic test_wakeup_order();
        set_slot(0, 6'd5, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 64'hA1);
        set_slot(1, 6'd6, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 64'hB1);
`ifdef INT_RS_CDB_BYPASS_EN
        exp_q.push_back(64'hA1);
        exp_q.push_back(64'hB1);
`else
        exp_q.push_back(64'hB1);
        exp_q.push_back(64'hA1);
`endif
        @(negedge clk);
        n_cmp++;
        if (bus.iss_valid !== 2'b01 || bus.iss_payload[63:0] !== 64'hB1) begin
            n_err++; $display("FAIL wake_before got %b/%h want 01/B1", bus.iss_valid,
                              bus.iss_payload[63:0]);
        end
        clear_inputs();
        set_cdb(0, 6'd5);
        bus.iss_ready = 2'b11;
        @(negedge clk);
        bus.cdb_valid = '0;
`ifdef INT_RS_CDB_BYPASS_EN
        n_cmp++;
        if (bus.occupancy !== 4'd0) begin
            n_err++; $display("FAIL wake_bypass_occ got %0d want 0", bus.occupancy);
        end
`else
        n_cmp++;
        if (bus.iss_valid !== 2'b01 || bus.iss_payload[63:0] !== 64'hA1) begin
            n_err++; $display("FAIL wake_after got %b/%h want 01/A1", bus.iss_valid,
                              bus.iss_payload[63:0]);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.occupancy !== 4'd0) begin
            n_err++; $display("FAIL wake_occ got %0d want 0", bus.occupancy);
        end
`endif
        clear_inputs();
    endtask

    task automatic test_cdb_at_dispatch();
        set_slot(0, 6'd0, 1'b0, 1'b0, 6'd7, 1'b1, 1'b0, 64'hE0);
        set_slot(1, 6'd11, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 64'hE1);
        set_cdb(0, 6'd7);
        set_cdb(1, 6'd11);
        exp_q.push_back(64'hE0);
        exp_q.push_back(64'hE1);
        @(negedge clk);
        clear_inputs();
        n_cmp++;
        if (bus.iss_valid !== 2'b11) begin
            n_err++; $display("FAIL cdb_disp_valid got %b want 11", bus.iss_valid);
        end
        bus.iss_ready = 2'b11;
        @(negedge clk);
        n_cmp++;
        if (bus.occupancy !== 4'd0) begin
            n_err++; $display("FAIL cdb_disp_occ got %0d want 0", bus.occupancy);
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        set_slot(0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 64'hC0);
        set_slot(1, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 64'hD0);
        exp_q.push_back(64'hC0);
        exp_q.push_back(64'hD0);
        @(negedge clk);
        n_cmp++;
        if (bus.iss_valid !== 2'b11) begin
            n_err++; $display("FAIL bp_valid got %b want 11", bus.iss_valid);
        end
        clear_inputs();
        bus.iss_ready = 2'b01;
        @(negedge clk);
        n_cmp++;
        if (bus.occupancy !== 4'd1 || bus.iss_valid !== 2'b01 ||
            bus.iss_payload[63:0] !== 64'hD0) begin
            n_err++; $display("FAIL bp_represent got occ %0d %b/%h want 1 01/D0",
                              bus.occupancy, bus.iss_valid, bus.iss_payload[63:0]);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.occupancy !== 4'd0) begin
            n_err++; $display("FAIL bp_occ got %0d want 0", bus.occupancy);
        end
        clear_inputs();
    endtask

    task automatic test_full();
        int cyc;
        for (int p = 0; p < 3; p++) begin
            clear_inputs();
            set_slot(0, 6'd9, (p != 0), 1'b0, 6'd0, 1'b0, 1'b0, 64'hF0 + 64'(2*p));
            set_slot(1, 6'd9, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 64'hF1 + 64'(2*p));
            exp_q.push_back(64'hF0 + 64'(2*p));
            exp_q.push_back(64'hF1 + 64'(2*p));
            @(negedge clk);
        end
        n_cmp++;
        if (bus.disp_ready !== 1'b1 || bus.occupancy !== 4'd6) begin
            n_err++; $display("FAIL full_six got %b/%0d want 1/6", bus.disp_ready, bus.occupancy);
        end
        clear_inputs();
        set_slot(0, 6'd9, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 64'hF6);
        exp_q.push_back(64'hF6);
        @(negedge clk);
        n_cmp++;
        if (bus.disp_ready !== 1'b0 || bus.occupancy !== 4'd7) begin
            n_err++; $display("FAIL full_seven got %b/%0d want 0/7", bus.disp_ready, bus.occupancy);
        end
        clear_inputs();
        set_slot(0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 64'hDEAD0);
        set_slot(1, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 64'hDEAD1);
        bus.iss_ready = 2'b01;
        @(negedge clk);
        n_cmp++;
        if (bus.disp_ready !== 1'b1 || bus.occupancy !== 4'd6) begin
            n_err++; $display("FAIL full_refuse got %b/%0d want 1/6", bus.disp_ready, bus.occupancy);
        end
        clear_inputs();
        set_cdb(1, 6'd9);
        bus.iss_ready = 2'b11;
        @(negedge clk);
        bus.cdb_valid = '0;
        cyc = 0;
        while (bus.occupancy !== 4'd0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (bus.occupancy !== 4'd0) begin
            n_err++; $display("FAIL full_drain got %0d want 0", bus.occupancy);
        end
        clear_inputs();
    endtask

    task automatic test_flush();
        for (int p = 0; p < 3; p++) begin
            clear_inputs();
            set_slot(0, 6'd20, (p != 0), 1'b0, 6'd0, 1'b0, 1'b0, 64'h900 + 64'(p));
            if (p < 2) begin
                set_slot(1, 6'd20, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 64'h910 + 64'(p));
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bus.occupancy !== 4'd5 || bus.iss_valid !== 2'b01) begin
            n_err++; $display("FAIL flush_pre got %0d/%b want 5/01", bus.occupancy, bus.iss_valid);
        end
        clear_inputs();
        set_slot(0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 64'h9A0);
        set_slot(1, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 64'h9A1);
        bus.iss_ready = 2'b11;
        flush = 1'b1;
        #1;
        n_cmp++;
        if (bus.iss_valid !== 2'b00) begin
            n_err++; $display("FAIL flush_same_cycle got %b want 00", bus.iss_valid);
        end
        @(negedge clk);
        clear_inputs();
        n_cmp++;
        if (bus.occupancy !== 4'd0 || bus.iss_valid !== 2'b00) begin
            n_err++; $display("FAIL flush_after got %0d/%b want 0/00", bus.occupancy, bus.iss_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.occupancy !== 4'd0) begin
            n_err++; $display("FAIL flush_no_accept got %0d want 0", bus.occupancy);
        end
    endtask

    task automatic test_drained();
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL sb_leftover got %0d want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_dual_issue();
        test_wakeup_order();
        test_cdb_at_dispatch();
        test_backpressure();
        test_full();
        test_flush();
        test_drained();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
